// File: rtl/nexys_io_pkg.sv
// Shared constants and types for the Nexys board input conditioner.
package nexys_io_pkg;

    localparam int unsigned NUM_BTN                 = 4;
    localparam int unsigned NUM_SW                  = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } rst_state_t;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchronizer, stability counter, debounced level and
// registered one-cycle edge pulses.
module debounce_channel
    import nexys_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned     CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CW-1:0]          cnt;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Any cycle back at the stable level restarts the count from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt   <= '0;
                level <= synced;
                rise  <= synced;
                fall  <= ~synced;
            end
        end
    end

endmodule

// File: rtl/nexys_input_conditioner.sv
// Board input conditioning: debounced buttons/switches with edge pulses and
// a stretched, synchronously released SoC reset.
module nexys_input_conditioner
    import nexys_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES    = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned RST_STRETCH_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_i,
    input  logic [NUM_SW-1:0]  sw_i,
    output logic [NUM_BTN-1:0] btn_o,
    output logic [NUM_SW-1:0]  sw_o,
    output logic [NUM_BTN-1:0] btn_rise_o,
    output logic [NUM_BTN-1:0] btn_fall_o,
    output logic               soc_rst_n_o
);

    localparam int unsigned   SCW         = cnt_width(RST_STRETCH_CYCLES);
    localparam logic [SCW-1:0] STRETCH_MAX = SCW'(RST_STRETCH_CYCLES - 1);

    logic [NUM_SW-1:0] sw_rise_unused;
    logic [NUM_SW-1:0] sw_fall_unused;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_i[i]),
            .level(btn_o[i]),
            .rise (btn_rise_o[i]),
            .fall (btn_fall_o[i])
        );
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (sw_i[i]),
            .level(sw_o[i]),
            .rise (sw_rise_unused[i]),
            .fall (sw_fall_unused[i])
        );
    end

    rst_state_t     state, state_next;
    logic [SCW-1:0] stretch_cnt, stretch_next;
    logic           soc_rst_q;

    // Output flop follows the next state so release lands on the RUN-entry edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HOLD;
            stretch_cnt <= '0;
            soc_rst_q   <= 1'b0;
        end else begin
            state       <= state_next;
            stretch_cnt <= stretch_next;
            soc_rst_q   <= (state_next == RUN);
        end
    end

    always_comb begin
        state_next   = state;
        stretch_next = stretch_cnt;
        case (state)
            HOLD: begin
                if (stretch_cnt == STRETCH_MAX) begin
                    state_next   = RUN;
                    stretch_next = '0;
                end else begin
                    stretch_next = stretch_cnt + 1'b1;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = HOLD;
        endcase
    end

    assign soc_rst_n_o = soc_rst_q;

endmodule

// File: tb/tb_nexys_input_conditioner.sv
// Scoreboard bench: stimulus queues expected output events, a negedge monitor
// pops and compares whenever the outputs change or a pulse is present.
module tb_nexys_input_conditioner;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_i;
    logic [3:0] sw_i;
    logic [3:0] btn_o;
    logic [3:0] sw_o;
    logic [3:0] btn_rise_o;
    logic [3:0] btn_fall_o;
    logic       soc_rst_n_o;

    nexys_input_conditioner #(
        .DEBOUNCE_CYCLES   (8),
        .SYNC_STAGES       (2),
        .RST_STRETCH_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_i      (btn_i),
        .sw_i       (sw_i),
        .btn_o      (btn_o),
        .sw_o       (sw_o),
        .btn_rise_o (btn_rise_o),
        .btn_fall_o (btn_fall_o),
        .soc_rst_n_o(soc_rst_n_o)
    );

    typedef struct {
        int unsigned stamp;
        logic [3:0]  btn;
        logic [3:0]  sw;
        logic [3:0]  rise;
        logic [3:0]  fall;
        logic        soc;
    } ev_t;

    ev_t         sb[$];
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int unsigned cyc    = 0;
    logic [8:0]  prev_lv = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t        e;
        logic [8:0] lv;
        lv = {soc_rst_n_o, sw_o, btn_o};
        if (lv !== prev_lv || btn_rise_o !== 4'b0 || btn_fall_o !== 4'b0) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d actual btn=%b sw=%b rise=%b fall=%b soc=%b required no event",
                         cyc, btn_o, sw_o, btn_rise_o, btn_fall_o, soc_rst_n_o);
            end else begin
                e = sb.pop_front();
                if (e.stamp != cyc || e.btn !== btn_o || e.sw !== sw_o ||
                    e.rise !== btn_rise_o || e.fall !== btn_fall_o || e.soc !== soc_rst_n_o) begin
                    n_fail++;
                    $display("FAIL event actual cyc=%0d btn=%b sw=%b rise=%b fall=%b soc=%b required cyc=%0d btn=%b sw=%b rise=%b fall=%b soc=%b",
                             cyc, btn_o, sw_o, btn_rise_o, btn_fall_o, soc_rst_n_o,
                             e.stamp, e.btn, e.sw, e.rise, e.fall, e.soc);
                end
            end
        end
        prev_lv = lv;
    end

    task automatic push(input int unsigned stamp, input logic [3:0] btn, input logic [3:0] sw,
                        input logic [3:0] rise, input logic [3:0] fall, input logic soc);
        ev_t e;
        e.stamp = stamp;
        e.btn   = btn;
        e.sw    = sw;
        e.rise  = rise;
        e.fall  = fall;
        e.soc   = soc;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int unsigned c;
        rst_n = 1'b1;
        btn_i = '0;
        sw_i  = '0;

        // Reset low for 10 ns, release 1 ns after a falling clock edge
        #1 rst_n = 1'b0;
        #6;
        check("reset_outputs", 32'({btn_o, sw_o, btn_rise_o, btn_fall_o, soc_rst_n_o}), 32'd0);
        #4 rst_n = 1'b1;
        push(cyc + 16, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        wait_cycles(20);

        // Single press and release on btn[0]
        c = cyc;
        btn_i[0] = 1'b1;
        push(c + 10, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1);
        wait_cycles(15);
        c = cyc;
        btn_i[0] = 1'b0;
        push(c + 10, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        wait_cycles(15);

        // Short glitches on btn[1]: 5 and 7 cycles never reach the output
        btn_i[1] = 1'b1;
        wait_cycles(5);
        btn_i[1] = 1'b0;
        wait_cycles(15);
        check("glitch5_level", 32'(btn_o), 32'd0);
        btn_i[1] = 1'b1;
        wait_cycles(7);
        btn_i[1] = 1'b0;
        wait_cycles(15);
        check("glitch7_level", 32'(btn_o), 32'd0);

        // btn[2]: 7 high, 1 low, then held; count restarts after the dip
        c = cyc;
        btn_i[2] = 1'b1;
        wait_cycles(7);
        btn_i[2] = 1'b0;
        wait_cycles(1);
        btn_i[2] = 1'b1;
        push(c + 18, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b1);
        wait_cycles(15);
        c = cyc;
        btn_i[2] = 1'b0;
        push(c + 10, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b1);
        wait_cycles(15);

        // Switches bounce every 3 cycles for 30 cycles, then settle at 1010
        for (int unsigned k = 0; k < 10; k++) begin
            sw_i = (k % 2 == 0) ? 4'b1010 : 4'b0000;
            wait_cycles(3);
        end
        sw_i = 4'b1010;
        push(cyc + 10, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 1'b1);
        wait_cycles(15);

        // All four buttons together
        c = cyc;
        btn_i = 4'b1111;
        push(c + 10, 4'b1111, 4'b1010, 4'b1111, 4'b0000, 1'b1);
        wait_cycles(15);
        c = cyc;
        btn_i = 4'b0000;
        push(c + 10, 4'b0000, 4'b1010, 4'b0000, 4'b1111, 1'b1);
        wait_cycles(15);

        // Reset with btn[3] counter at 6 of 8; sw stays high across reset
        c = cyc;
        btn_i[3] = 1'b1;
        wait_cycles(8);
        rst_n = 1'b0;
        push(c + 9, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        #1;
        check("async_reset_sw", 32'(sw_o), 32'd0);
        check("async_reset_soc", 32'(soc_rst_n_o), 32'd0);
        wait_cycles(3);
        c = cyc;
        rst_n = 1'b1;
        push(c + 10, 4'b1000, 4'b1010, 4'b1000, 4'b0000, 1'b0);
        push(c + 16, 4'b1000, 4'b1010, 4'b0000, 4'b0000, 1'b1);
        wait_cycles(25);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nexys_input_conditioner.md
NEXYS_INPUT_CONDITIONER -- requirements
Module: nexys_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles needed before an output changes (10 ms at 100 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flip-flop depth of each input synchronizer (minimum 2).
REQ-003 SHALL have parameter RST_STRETCH_CYCLES, default 16, cycles soc_rst_n_o stays low after rst_n deasserts.
REQ-004 SHALL have port clk, input, 1, single 100 MHz board clock; all logic in this one domain.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset (board ck_rst).
REQ-006 SHALL have port btn_i, input, 4, raw asynchronous push buttons.
REQ-007 SHALL have port sw_i, input, 4, raw asynchronous slide switches.
REQ-008 SHALL have port btn_o, output, 4, debounced button levels.
REQ-009 SHALL have port sw_o, output, 4, debounced switch levels.
REQ-010 SHALL have port btn_rise_o, output, 4, one-cycle pulse per debounced button 0->1.
REQ-011 SHALL have port btn_fall_o, output, 4, one-cycle pulse per debounced button 1->0.
REQ-012 SHALL have port soc_rst_n_o, output, 1, conditioned active-low reset driven to the SoC top.

Function
REQ-013 SHALL pass each of the 8 inputs (btn_i, sw_i) through its own SYNC_STAGES-deep synchronizer before any other use.
REQ-014 SHALL keep, per channel, a stable level and a counter wide enough to hold DEBOUNCE_CYCLES-1.
REQ-015 SHALL clear the counter on any cycle where the synchronized input equals the stable level.
REQ-016 SHALL increment the counter on any cycle where they differ and the counter is below DEBOUNCE_CYCLES-1.
REQ-017 SHALL, on a cycle where they differ and the counter equals DEBOUNCE_CYCLES-1, load the stable level with the synchronized input and clear the counter.
REQ-018 SHALL change an output exactly SYNC_STAGES+DEBOUNCE_CYCLES clock edges after a raw input change that then stays constant.
REQ-019 SHALL never change an output for a glitch shorter than DEBOUNCE_CYCLES cycles (after synchronization); any return to the stable level restarts the count from 0.
REQ-020 SHALL assert btn_rise_o[i] / btn_fall_o[i] for exactly one cycle, registered, on the edge that updates btn_o[i]; rise and fall never assert together for the same bit.
REQ-021 SHALL treat all channels independently; simultaneous changes on several channels produce simultaneous, independent updates.
REQ-022 SHALL implement reset stretching as FSM with states HOLD and RUN: HOLD counts cycles after rst_n deasserts, moves to RUN when the count reaches RST_STRETCH_CYCLES-1; RUN holds soc_rst_n_o high.
REQ-023 SHALL assert soc_rst_n_o low asynchronously on rst_n low and deassert it synchronously to clk only on entry to RUN.

Reset
REQ-024 SHALL, while rst_n is low, force btn_o=0, sw_o=0, btn_rise_o=0, btn_fall_o=0, soc_rst_n_o=0, all counters and synchronizer flops to 0, FSM to HOLD.
REQ-025 SHALL, on rst_n assertion mid-debounce or mid-stretch, abandon the operation; after release, inputs already high are debounced afresh from 0 without generating spurious fall pulses.

Structure
REQ-026 SHALL place NUM_BTN=4, NUM_SW=4, default DEBOUNCE_CYCLES and the reset FSM state enum in shared package nexys_io_pkg.
REQ-027 SHALL implement one channel (synchronizer, counter, stable level, edge pulses) as sub-module debounce_channel, instantiated 8 times.

Verification
REQ-028 SHALL cover rst_n low 10 ns then high, RST_STRETCH_CYCLES=16 -> soc_rst_n_o low, rising on the 16th clk edge after release.
REQ-029 SHALL cover DEBOUNCE_CYCLES=8: btn_i[0] 0->1 held -> btn_o[0]=1 and btn_rise_o[0] single pulse exactly 10 edges later.
REQ-030 SHALL cover btn_i[1] high for 5 cycles then low (DEBOUNCE_CYCLES=8) -> btn_o[1] stays 0, no pulses.
REQ-031 SHALL cover sw_i=4'b1010 bouncing (toggling every 3 cycles for 30 cycles) then settling -> sw_o=4'b1010 exactly 10 edges after last toggle.
REQ-032 SHALL cover rst_n asserted with counter at 6 of 8 -> all outputs 0 immediately; after release, held input reaches output after a full 10 edges.
REQ-033 SHALL cover btn_i=4'b1111 simultaneous press then release -> four rise pulses same cycle, later four fall pulses same cycle.
